serdesphy_rx_link_ctrl: RTL and testbench
=========================================

SERDESPHY_RX_LINK_CTRL -- requirements
Module: serdesphy_rx_link_ctrl

Interface
REQ-001 The block SHALL have parameter LOCK_TIMEOUT, default 16'd2400, giving the maximum clk_24m cycles to wait for cdr_lock.
REQ-002 The block SHALL have parameter ALIGN_TIMEOUT, default 16'd4800, giving the maximum clk_24m cycles to wait for rx_aligned.
REQ-003 The block SHALL have parameter ALIGN_RST_CYCLES, default 16'd4, giving the rx_align_rst pulse width in cycles (legal range 1..65535).
REQ-004 The block SHALL have parameter BACKOFF_CYCLES, default 16'd240, giving the cycles rx_en is held low between attempts (legal range 1..65535).
REQ-005 The block SHALL have parameter MAX_RETRY, default 4'd3, giving the number of failed attempts tolerated before FAIL (legal range 1..15).
REQ-006 The block SHALL have a single clock and a synchronous active-high reset: clk_24m  input  1  24 MHz system clock; rst_24m  input  1  synchronous active-high reset.
REQ-007 The block SHALL have the ports: link_start  input  1  level request to bring up and hold the RX link; cdr_lock  input  1  CDR lock, already synchronised to clk_24m; rx_aligned  input  1  alignment status from the RX datapath; rx_error  input  1  RX error flag from the RX datapath.
REQ-008 The block SHALL have the ports: rx_en  output  1  RX enable; rx_fifo_en  output  1  RX FIFO enable; rx_align_rst  output  1  alignment FSM reset pulse; link_up  output  1  link operational.
REQ-009 The block SHALL have the ports: link_fail  output  1  retries exhausted; retry_count  output  4  failed attempts in the current request; link_state  output  3  FSM state encoding.

Function
REQ-010 The FSM states SHALL be IDLE=0, WAIT_LOCK=1, ALIGN_RST=2, WAIT_ALIGN=3, LINK_UP=4, BACKOFF=5, FAIL=6; encoding 7 is illegal and SHALL go to IDLE on the next cycle.
REQ-011 All outputs SHALL be registered and SHALL be decoded from the current state (Moore).
- rx_en=1 in ALIGN_RST, WAIT_ALIGN and LINK_UP only.
- rx_align_rst=1 in ALIGN_RST only.
- rx_fifo_en=1 and link_up=1 in LINK_UP only.
- link_fail=1 in FAIL only.
REQ-012 A single 16-bit timer SHALL clear on every state entry and SHALL increment once per cycle while in WAIT_LOCK, ALIGN_RST, WAIT_ALIGN or BACKOFF.
REQ-013 link_start=0 in any non-IDLE state SHALL cause a transition to IDLE on the next cycle; this has the highest priority after reset.
REQ-014 IDLE with link_start=1 SHALL go to WAIT_LOCK and clear retry_count to 0.
REQ-015 WAIT_LOCK SHALL transition as follows:
- cdr_lock=1 -> ALIGN_RST.
- otherwise, timer==LOCK_TIMEOUT-1 -> BACKOFF.
- if cdr_lock rises on the timeout cycle, the lock SHALL win.
REQ-016 ALIGN_RST SHALL last exactly ALIGN_RST_CYCLES cycles and then go to WAIT_ALIGN; cdr_lock=0 during ALIGN_RST SHALL go to BACKOFF.
REQ-017 WAIT_ALIGN SHALL transition in this priority order:
- cdr_lock=0 -> BACKOFF.
- rx_aligned=1 -> LINK_UP.
- timer==ALIGN_TIMEOUT-1 -> BACKOFF.
REQ-018 LINK_UP SHALL go to BACKOFF when cdr_lock=0, rx_aligned=0 or rx_error=1; otherwise it SHALL stay in LINK_UP indefinitely.
REQ-019 Every entry into BACKOFF SHALL increment retry_count; the increment SHALL saturate at 15 and SHALL never wrap.
REQ-020 BACKOFF SHALL exit when timer==BACKOFF_CYCLES-1, as follows:
- retry_count>=MAX_RETRY -> FAIL.
- otherwise -> WAIT_LOCK.
REQ-021 FAIL SHALL hold link_fail=1 until link_start=0, then go to IDLE; cdr_lock, rx_aligned and rx_error SHALL be ignored while in FAIL.
REQ-022 A successful entry into LINK_UP SHALL NOT clear retry_count; only the IDLE->WAIT_LOCK transition clears it.
REQ-023 Latency: every output SHALL reflect a state change on the same edge that updates link_state, one cycle after the causing input is sampled.

Reset
REQ-024 When rst_24m=1 at a clk_24m edge, the block SHALL set state=IDLE, timer=0 and retry_count=0.
REQ-025 During reset, rx_en, rx_fifo_en, rx_align_rst, link_up and link_fail SHALL all be 0 and link_state SHALL be 3'd0.
REQ-026 Reset asserted mid-operation, including in LINK_UP or FAIL, SHALL take effect at the next edge with no residual state kept.

Structure
REQ-027 The state encodings and the default timeout constants SHALL live in the shared package serdesphy_pkg, for reuse by CSR decode and by the testbench.
REQ-028 The block SHALL be a single module with no sub-modules, since the timer is inline.

Verification
REQ-029 The bench SHALL cover the clean bring-up: link_start=1, cdr_lock=1 at cycle 10, rx_aligned=1 at cycle 30 -> rx_align_rst high for 4 cycles, link_up=1, rx_fifo_en=1, retry_count=0.
REQ-030 The bench SHALL cover lock timeout: link_start=1, cdr_lock held 0 -> BACKOFF entered at cycle 2401 with retry_count=1 and rx_en=0 for 240 cycles; after 3 attempts link_fail=1, link_state=6.
REQ-031 The bench SHALL cover loss of alignment: in LINK_UP, drop rx_aligned for 1 cycle -> link_up=0 next cycle, retry_count increments, then a new ALIGN_RST pulse follows.
REQ-032 The bench SHALL cover the simultaneous lock/timeout case: cdr_lock rises exactly at timer=LOCK_TIMEOUT-1 -> ALIGN_RST is entered, not BACKOFF.
REQ-033 The bench SHALL cover request withdrawal: deassert link_start in WAIT_ALIGN and in FAIL -> IDLE next cycle with all outputs 0; reassert -> retry_count=0.
REQ-034 The bench SHALL cover mid-operation reset: assert rst_24m for 1 cycle while in LINK_UP -> all outputs 0 and link_state=0 after the edge.

Source files
------------

// File: rtl/serdesphy_pkg.sv
// Shared RX link-control encodings and default timing constants, reused by CSR decode and benches.
package serdesphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_ALIGN_RST  = 3'd2,
        ST_WAIT_ALIGN = 3'd3,
        ST_LINK_UP    = 3'd4,
        ST_BACKOFF    = 3'd5,
        ST_FAIL       = 3'd6
    } link_state_t;

    localparam logic [15:0] LOCK_TIMEOUT_DEF     = 16'd2400;
    localparam logic [15:0] ALIGN_TIMEOUT_DEF    = 16'd4800;
    localparam logic [15:0] ALIGN_RST_CYCLES_DEF = 16'd4;
    localparam logic [15:0] BACKOFF_CYCLES_DEF   = 16'd240;
    localparam logic [3:0]  MAX_RETRY_DEF        = 4'd3;

    typedef struct packed {
        logic rx_en;
        logic rx_fifo_en;
        logic rx_align_rst;
        logic link_up;
        logic link_fail;
    } link_out_t;

endpackage

// File: rtl/serdesphy_rx_link_ctrl.sv
// RX link bring-up sequencer: CDR lock, align reset, alignment wait, retry with backoff.
// Latency: outputs and link_state update on the same edge, one cycle after the causing input.
// Backpressure: none; link_start is a level request, withdrawal returns to IDLE next cycle.
module serdesphy_rx_link_ctrl
    import serdesphy_pkg::*;
#(
    parameter logic [15:0] LOCK_TIMEOUT     = LOCK_TIMEOUT_DEF,
    parameter logic [15:0] ALIGN_TIMEOUT    = ALIGN_TIMEOUT_DEF,
    parameter logic [15:0] ALIGN_RST_CYCLES = ALIGN_RST_CYCLES_DEF,
    parameter logic [15:0] BACKOFF_CYCLES   = BACKOFF_CYCLES_DEF,
    parameter logic [3:0]  MAX_RETRY        = MAX_RETRY_DEF
) (
    input  logic       clk_24m,
    input  logic       rst_24m,
    input  logic       link_start,
    input  logic       cdr_lock,
    input  logic       rx_aligned,
    input  logic       rx_error,
    output logic       rx_en,
    output logic       rx_fifo_en,
    output logic       rx_align_rst,
    output logic       link_up,
    output logic       link_fail,
    output logic [3:0] retry_count,
    output logic [2:0] link_state
);

    localparam logic [15:0] LOCK_LAST    = LOCK_TIMEOUT - 16'd1;
    localparam logic [15:0] ALIGN_LAST   = ALIGN_TIMEOUT - 16'd1;
    localparam logic [15:0] ARST_LAST    = ALIGN_RST_CYCLES - 16'd1;
    localparam logic [15:0] BACKOFF_LAST = BACKOFF_CYCLES - 16'd1;

    link_state_t state;
    link_state_t state_nxt;
    logic [15:0] timer;
    logic        timer_run;
    link_out_t   outs;
    link_out_t   outs_nxt;

    always_ff @(posedge clk_24m) begin
        if (rst_24m) begin
            state       <= ST_IDLE;
            timer       <= 16'd0;
            retry_count <= 4'd0;
            outs        <= '0;
        end else begin
            state <= state_nxt;
            outs  <= outs_nxt;
            if (state_nxt != state)
                timer <= 16'd0;
            else if (timer_run)
                timer <= timer + 16'd1;
            if (state == ST_IDLE && state_nxt == ST_WAIT_LOCK)
                retry_count <= 4'd0;
            else if (state_nxt == ST_BACKOFF && state != ST_BACKOFF && retry_count != 4'hF)
                retry_count <= retry_count + 4'd1;
        end
    end

    always_comb begin
        timer_run = (state == ST_WAIT_LOCK) || (state == ST_ALIGN_RST) ||
                    (state == ST_WAIT_ALIGN) || (state == ST_BACKOFF);
    end

    // Withdrawal of the request overrides every other condition, including FAIL.
    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && !link_start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (link_start) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (cdr_lock)                state_nxt = ST_ALIGN_RST;
                    else if (timer == LOCK_LAST) state_nxt = ST_BACKOFF;
                end
                ST_ALIGN_RST: begin
                    if (!cdr_lock)               state_nxt = ST_BACKOFF;
                    else if (timer == ARST_LAST) state_nxt = ST_WAIT_ALIGN;
                end
                ST_WAIT_ALIGN: begin
                    if (!cdr_lock)                state_nxt = ST_BACKOFF;
                    else if (rx_aligned)          state_nxt = ST_LINK_UP;
                    else if (timer == ALIGN_LAST) state_nxt = ST_BACKOFF;
                end
                ST_LINK_UP: begin
                    if (!cdr_lock || !rx_aligned || rx_error) state_nxt = ST_BACKOFF;
                end
                ST_BACKOFF: begin
                    if (timer == BACKOFF_LAST)
                        state_nxt = (retry_count >= MAX_RETRY) ? ST_FAIL : ST_WAIT_LOCK;
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Decoding the next state keeps outputs registered yet aligned with link_state.
    always_comb begin
        outs_nxt = '0;
        case (state_nxt)
            ST_ALIGN_RST: begin
                outs_nxt.rx_en        = 1'b1;
                outs_nxt.rx_align_rst = 1'b1;
            end
            ST_WAIT_ALIGN: outs_nxt.rx_en = 1'b1;
            ST_LINK_UP: begin
                outs_nxt.rx_en      = 1'b1;
                outs_nxt.rx_fifo_en = 1'b1;
                outs_nxt.link_up    = 1'b1;
            end
            ST_FAIL: outs_nxt.link_fail = 1'b1;
            default: outs_nxt = '0;
        endcase
    end

    assign rx_en        = outs.rx_en;
    assign rx_fifo_en   = outs.rx_fifo_en;
    assign rx_align_rst = outs.rx_align_rst;
    assign link_up      = outs.link_up;
    assign link_fail    = outs.link_fail;
    assign link_state   = state;

endmodule

// File: tb/tb_serdesphy_rx_link_ctrl.sv
// Bench for serdesphy_rx_link_ctrl: step table plus hand-written bring-up, timeout and reset sequences.
module tb_serdesphy_rx_link_ctrl;
    import serdesphy_pkg::*;

    localparam logic [2:0] S_IDLE = 3'd0, S_WL = 3'd1, S_AR = 3'd2, S_WA = 3'd3,
                           S_LU = 3'd4, S_BO = 3'd5, S_FAIL = 3'd6;

    logic       clk_24m = 1'b0;
    logic       rst_24m;
    logic       link_start, cdr_lock, rx_aligned, rx_error;
    logic       rx_en, rx_fifo_en, rx_align_rst, link_up, link_fail;
    logic [3:0] retry_count;
    logic [2:0] link_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] st;
        logic [3:0] rc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       ls, lock, al, err;
        int         n;
        logic [2:0] st;
        logic [3:0] rc;
    } vec_t;
    vec_t tbl[19];

    always #5 clk_24m = ~clk_24m;

    serdesphy_rx_link_ctrl #(
        .LOCK_TIMEOUT(16'd2400), .ALIGN_TIMEOUT(16'd4800), .ALIGN_RST_CYCLES(16'd4),
        .BACKOFF_CYCLES(16'd240), .MAX_RETRY(4'd3)
    ) dut (
        .clk_24m(clk_24m), .rst_24m(rst_24m), .link_start(link_start), .cdr_lock(cdr_lock),
        .rx_aligned(rx_aligned), .rx_error(rx_error), .rx_en(rx_en), .rx_fifo_en(rx_fifo_en),
        .rx_align_rst(rx_align_rst), .link_up(link_up), .link_fail(link_fail),
        .retry_count(retry_count), .link_state(link_state)
    );

    // {rx_en, rx_fifo_en, rx_align_rst, link_up, link_fail} expected for each state
    function automatic logic [4:0] exp_outs(input logic [2:0] st);
        case (st)
            S_AR:    return 5'b10100;
            S_WA:    return 5'b10000;
            S_LU:    return 5'b11010;
            S_FAIL:  return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_24m);
        #1;
    endtask

    task automatic chk_val(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [3:0] rc);
        logic [4:0] o;
        o = {rx_en, rx_fifo_en, rx_align_rst, link_up, link_fail};
        checks++;
        if (link_state !== st) begin
            errors++;
            $display("FAIL %s link_state: got %0d, expected %0d", nm, link_state, st);
        end
        checks++;
        if (retry_count !== rc) begin
            errors++;
            $display("FAIL %s retry_count: got %0d, expected %0d", nm, retry_count, rc);
        end
        checks++;
        if (o !== exp_outs(st)) begin
            errors++;
            $display("FAIL %s outputs: got %b, expected %b", nm, o, exp_outs(st));
        end
    endtask

    task automatic step(input logic ls, input logic lock, input logic al, input logic err,
                        input int n, input logic [2:0] st, input logic [3:0] rc, input string nm);
        exp_t e;
        link_start = ls;
        cdr_lock   = lock;
        rx_aligned = al;
        rx_error   = err;
        e.st = st;
        e.rc = rc;
        exp_q.push_back(e);
        tick(n);
        e = exp_q.pop_front();
        chk(nm, e.st, e.rc);
    endtask

    initial begin
        int n_hi;
        int cyc;
        int rx_en_seen;

        // Starts in LINK_UP with retry_count 0, cdr_lock=1, rx_aligned=1.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   S_BO,   4'd1};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 239, S_BO,   4'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,   S_WL,   4'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,   S_AR,   4'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3,   S_AR,   4'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,   S_WA,   4'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,   S_LU,   4'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1,   S_BO,   4'd2};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 240, S_WL,   4'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   S_AR,   4'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4,   S_WA,   4'd2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   S_BO,   4'd3};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 240, S_FAIL, 4'd3};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 5,   S_FAIL, 4'd3};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1,   S_IDLE, 4'd3};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   S_WL,   4'd0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   S_AR,   4'd0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   S_BO,   4'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,   S_IDLE, 4'd1};

        rst_24m = 1'b1;
        link_start = 1'b0; cdr_lock = 1'b0; rx_aligned = 1'b0; rx_error = 1'b0;
        tick(2);
        chk("reset", S_IDLE, 4'd0);
        rst_24m = 1'b0;

        // Clean bring-up: lock at cycle 10, alignment at cycle 30.
        step(1, 0, 0, 0, 1,  S_WL, 4'd0, "start");
        step(1, 0, 0, 0, 9,  S_WL, 4'd0, "wait_lock");
        step(1, 1, 0, 0, 1,  S_AR, 4'd0, "lock_seen");
        n_hi = 1;
        for (int i = 0; i < 20 && rx_align_rst; i++) begin
            tick(1);
            if (rx_align_rst) n_hi++;
        end
        chk_val("align_rst_width", n_hi, 4);
        chk("wait_align", S_WA, 4'd0);
        step(1, 1, 0, 0, 15, S_WA, 4'd0, "wait_align_hold");
        step(1, 1, 1, 0, 1,  S_LU, 4'd0, "link_up");
        step(1, 1, 1, 0, 5,  S_LU, 4'd0, "link_up_hold");

        for (int i = 0; i < 19; i++)
            step(tbl[i].ls, tbl[i].lock, tbl[i].al, tbl[i].err, tbl[i].n,
                 tbl[i].st, tbl[i].rc, $sformatf("tbl%0d", i));

        // Lock timeout: BACKOFF on edge 2401 after the request, then FAIL after three attempts.
        link_start = 1'b1; cdr_lock = 1'b0; rx_aligned = 1'b0; rx_error = 1'b0;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (link_state != S_BO && cyc < 3000);
        chk_val("lock_timeout_cycle", cyc, 2401);
        chk("backoff_first", S_BO, 4'd1);
        n_hi = 0;
        rx_en_seen = 0;
        while (link_state == S_BO && n_hi < 1000) begin
            if (rx_en) rx_en_seen++;
            n_hi++;
            tick(1);
        end
        chk_val("backoff_len", n_hi, 240);
        chk_val("backoff_rx_en", rx_en_seen, 0);
        chk("retry_wait_lock", S_WL, 4'd1);
        cyc = 0;
        while (link_state != S_FAIL && cyc < 10000) begin
            tick(1);
            cyc++;
        end
        chk("lock_fail", S_FAIL, 4'd3);

        rst_24m = 1'b1;
        tick(1);
        chk("rst_in_fail", S_IDLE, 4'd0);
        rst_24m = 1'b0;
        step(1, 0, 0, 0, 1, S_WL, 4'd0, "restart");

        // Lock arrives on the very cycle the lock timer expires.
        step(1, 0, 0, 0, 2399, S_WL, 4'd0, "timer_last");
        step(1, 1, 0, 0, 1,    S_AR, 4'd0, "lock_at_timeout");

        step(1, 1, 0, 0, 4, S_WA,   4'd0, "wa_again");
        step(0, 1, 0, 0, 1, S_IDLE, 4'd0, "withdraw_wa");
        step(1, 1, 1, 0, 1, S_WL,   4'd0, "reassert");
        step(1, 1, 1, 0, 1, S_AR,   4'd0, "reassert_ar");
        step(1, 1, 1, 0, 4, S_WA,   4'd0, "reassert_wa");
        step(1, 1, 1, 0, 1, S_LU,   4'd0, "reassert_lu");

        rst_24m = 1'b1;
        tick(1);
        chk("rst_in_link_up", S_IDLE, 4'd0);
        rst_24m = 1'b0;
        step(1, 1, 1, 0, 1, S_WL, 4'd0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
